mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access pipeline stage directly downstream of the execute stage. It consumes the ALU result (effective address or pass-through value), store data and destination register from the EX/MEM register. It runs a req/ack handshake to data memory with byte/halfword/word lane steering, stalls upstream while an access is outstanding, and registers the write-back data into the MEM/WB boundary.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in BUSY before a bus error. Only used when MEM_TIMEOUT_EN is defined.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  reset, synchronous, active-high.
- InValid  in  1  EX/MEM holds a valid instruction.
- ALUResult  in  32  address for loads/stores; write-back value otherwise.
- StoreData  in  32  forwarded rt value for stores.
- MemRead, MemWrite  in  1 each  access type; never both high.
- MemSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- MemSigned  in  1  sign-extend loads when 1.
- RegWrite_In  in  1  instruction writes a register.
- RegDest_In  in  5  destination register.
- MemReq, MemWe  out  1 each  request strobe and write flag to data memory.
- MemAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- MemByteEn  out  4  lane enables.
- MemWData  out  32  lane-replicated store data.
- MemAck  in  1  access complete; MemRData is valid in the same cycle.
- MemRData  in  32  read word.
- Stall  out  1  hold EX/MEM and all earlier stages.
- WB_Valid, WB_RegWrite  out  1 each  MEM/WB control.
- WB_RegDest  out  5  MEM/WB destination.
- WB_Data  out  32  load data or ALUResult.
- AddrError  out  1  one-cycle pulse on a misaligned access.
- BusError  out  1  one-cycle pulse on a timeout (MEM_TIMEOUT_EN only).

## Operation
- States: IDLE and BUSY.
- IDLE, valid non-memory instruction: at the clock edge, WB_* <= {1, RegWrite_In, RegDest_In, ALUResult}. Stall is 0.
- IDLE, valid aligned memory op: Stall=1 combinationally. Next state BUSY. MemReq<=1, and MemWe/MemAddr/MemByteEn/MemWData are registered.
- BUSY: MemReq and the request fields are held stable, and Stall=1, until MemAck=1.
  - In the MemAck cycle, Stall=0.
  - At that edge, the WB registers capture the formatted load data (loads) or the write-back with WB_RegWrite=0 (stores).
  - At that edge, MemReq<=0 and the state returns to IDLE.
- MemAck is ignored while MemReq=0.
- Alignment:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
  - A misaligned op issues no request and raises no stall. AddrError pulses and WB_Valid<=0.
- Store steering:
  - Byte: byte replicated ×4, MemByteEn=4'b0001<<addr[1:0].
  - Half: half replicated ×2, MemByteEn=addr[1]?1100:0011.
  - Word: MemByteEn=1111.
- Load formatting: select the lane using addr[1:0] (byte) or addr[1] (half). Zero- or sign-extend per MemSigned.
- When InValid=0 in IDLE, WB_Valid<=0 and WB_RegWrite<=0.

## Timing
- Non-memory instruction: 1-cycle latency to WB.
- Memory op: at least 2 cycles. The earliest MemAck comes in the cycle after MemReq rises. Latency is 1 + memory wait cycles.
- MemReq never asserts in the same cycle an op arrives; it is registered.
- Reset values: all outputs 0 and state IDLE.
- Reset mid-BUSY: MemReq drops at that edge, the access is abandoned, and no WB write is produced.
- Back-to-back memory ops: the second op enters IDLE the cycle after the first op's MemAck and re-requests one cycle later. MemReq drops for at least one cycle between requests.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: MemReq<=0, state IDLE, BusError pulses, WB_Valid<=0, and Stall=0 in that cycle.
  - An ack in the same cycle as the timeout wins.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely, BusError is tied to 0, and no counter exists.

## Structure
- Shared package mem_pkg:
  - MemSize encodings (MEM_BYTE, MEM_HALF, MEM_WORD).
  - State enum {IDLE, BUSY}.
  - Default timeout constant.
- Sub-module lane_steer (combinational): store replication/byte-enable generation and load extraction/extension. It is instantiated once and shared by both paths.

## Test plan
- Word store addr 0x100, data 0xDEADBEEF, MemAck 3 cycles after MemReq → MemAddr 0x100, MemByteEn 1111, Stall high 4 cycles, WB_RegWrite 0.
- Signed byte load addr 0x103, MemRData 0x80FF_FF7F, ack after 1 cycle → WB_Data 0xFFFF_FF80. Repeat unsigned → 0x0000_0080.
- Half store addr 0x202, data 0x1234ABCD → MemWData 0xABCDABCD, MemByteEn 1100. Half load addr 0x201 → AddrError pulse, no MemReq, no stall.
- ADD result 0x55 to r9, then lw, then ADD → first WB 1 cycle after arrival, load WB after ack, MemReq low ≥1 cycle between accesses.
- Reset asserted in the 2nd BUSY cycle → MemReq 0 next cycle, all WB outputs 0, a later ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → BusError pulse in the 4th BUSY cycle, Stall released, WB_Valid 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory-access stage.
//   MemSize encodings (MEM_BYTE/HALF/WORD; 2'b11 is treated as a word),
//   the stage state type and the default bus timeout.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_access_stage_lane_steer.sv
// lane_steer: purely combinational lane logic shared by the store and load paths.
//   size       in  2   access size (MEM_BYTE/MEM_HALF/other = word)
//   addr_lo    in  2   low address bits selecting the lane
//   is_signed  in  1   sign-extend extracted load data
//   store_data in  32  raw store value
//   rdata      in  32  raw read word
//   wdata      out 32  lane-replicated store data
//   byte_en    out 4   lane enables
//   load_data  out 32  extracted and extended load value
module lane_steer
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    logic signed [7:0] sb;
    sb = b;
    return s ? 32'(signed'(sb)) : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    logic signed [15:0] sh;
    sh = h;
    return s ? 32'(signed'(sh)) : {16'b0, h};
  endfunction

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = rdata >> {addr_lo, 3'b000};
  assign half_sh = rdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    wdata     = store_data;
    byte_en   = 4'b1111;
    load_data = rdata;
    case (size)
      MEM_BYTE: begin
        wdata     = {4{store_data[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
        load_data = ext8(byte_sh[7:0], is_signed);
      end
      MEM_HALF: begin
        wdata     = {2{store_data[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = ext16(half_sh[15:0], is_signed);
      end
      default: begin
        wdata     = store_data;
        byte_en   = 4'b1111;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EX/MEM and MEM/WB.
// Runs a req/ack handshake to data memory with lane steering, stalls
// upstream while an access is outstanding, and registers write-back data.
// Optional feature macro: MEM_TIMEOUT_EN (bus timeout after TIMEOUT_CYCLES
// BUSY cycles without ack; BusError pulses). Undefined: BusError is 0.
// Ports:
//   Clock, Reset (sync, active-high)
//   InValid, ALUResult, StoreData, MemRead, MemWrite, MemSize, MemSigned,
//   RegWrite_In, RegDest_In                 - EX/MEM inputs
//   MemReq, MemWe, MemAddr, MemByteEn, MemWData, MemAck, MemRData - data bus
//   Stall                                   - hold EX/MEM and earlier
//   WB_Valid, WB_RegWrite, WB_RegDest, WB_Data - MEM/WB register
//   AddrError, BusError                     - one-cycle error pulses
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        RegWrite_In,
  input  logic [4:0]  RegDest_In,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic        WB_Valid,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_RegDest,
  output logic [31:0] WB_Data,
  output logic        AddrError,
  output logic        BusError
);

  state_t      state_p1;
  logic        req_p1;
  logic        we_p1;
  logic [31:0] maddr_p1;
  logic [3:0]  be_p1;
  logic [31:0] wdata_p1;
  logic [1:0]  size_p1;
  logic        signed_p1;
  logic [31:0] alu_p1;
  logic        is_load_p1;
  logic        rw_p1;
  logic [4:0]  rd_p1;
  logic        wb_vld_p2;
  logic        wb_rw_p2;
  logic [4:0]  wb_rd_p2;
  logic [31:0] wb_data_p2;
  logic        addr_err_p2;

  logic        is_mem;
  logic        misalign;
  logic        launch;
  logic        busy;
  logic        timeout;
  logic [1:0]  st_size;
  logic [1:0]  st_lo;
  logic        st_sign;
  logic [31:0] steer_wdata;
  logic [3:0]  steer_be;
  logic [31:0] steer_load;

  assign busy     = (state_p1 == BUSY);
  assign is_mem   = MemRead | MemWrite;
  // Reserved size 2'b11 shares the word alignment rule.
  assign misalign = ((MemSize == MEM_HALF) && ALUResult[0]) ||
                    (MemSize[1] && (ALUResult[1:0] != 2'b00));
  assign launch   = !busy && InValid && is_mem && !misalign;

  // One steering instance: IDLE steers the incoming store, BUSY formats the load.
  assign st_size = busy ? size_p1       : MemSize;
  assign st_lo   = busy ? alu_p1[1:0]   : ALUResult[1:0];
  assign st_sign = busy ? signed_p1     : MemSigned;

  lane_steer u_lane_steer (
    .size       (st_size),
    .addr_lo    (st_lo),
    .is_signed  (st_sign),
    .store_data (StoreData),
    .rdata      (MemRData),
    .wdata      (steer_wdata),
    .byte_en    (steer_be),
    .load_data  (steer_load)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_p1;

  // Count holds the BUSY cycles already elapsed, so the final cycle sees N-1.
  assign timeout  = busy && !MemAck && (tmo_cnt_p1 == 8'(TIMEOUT_CYCLES - 1));
  assign BusError = timeout;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tmo_cnt_p1 <= 8'd0;
    end else if (launch) begin
      tmo_cnt_p1 <= 8'd0;
    end else if (busy && !MemAck) begin
      tmo_cnt_p1 <= tmo_cnt_p1 + 8'd1;
    end
  end
`else
  assign timeout  = 1'b0;
  // Parameter stays referenced so both builds expose the same interface.
  assign BusError = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  assign Stall = launch || (busy && !MemAck && !timeout);

  // Stage p1: request issue / outstanding access; stage p2: MEM/WB register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_p1    <= IDLE;
      req_p1      <= 1'b0;
      we_p1       <= 1'b0;
      maddr_p1    <= 32'd0;
      be_p1       <= 4'd0;
      wdata_p1    <= 32'd0;
      wb_vld_p2   <= 1'b0;
      wb_rw_p2    <= 1'b0;
      wb_rd_p2    <= 5'd0;
      wb_data_p2  <= 32'd0;
      addr_err_p2 <= 1'b0;
    end else begin
      addr_err_p2 <= 1'b0;
      wb_vld_p2   <= 1'b0;
      wb_rw_p2    <= 1'b0;
      if (!busy) begin
        if (InValid && !is_mem) begin
          wb_vld_p2  <= 1'b1;
          wb_rw_p2   <= RegWrite_In;
          wb_rd_p2   <= RegDest_In;
          wb_data_p2 <= ALUResult;
        end else if (InValid && misalign) begin
          addr_err_p2 <= 1'b1;
        end else if (launch) begin
          state_p1 <= BUSY;
          req_p1   <= 1'b1;
          we_p1    <= MemWrite;
          maddr_p1 <= {ALUResult[31:2], 2'b00};
          be_p1    <= steer_be;
          wdata_p1 <= steer_wdata;
        end
      end else if (MemAck) begin
        state_p1   <= IDLE;
        req_p1     <= 1'b0;
        wb_vld_p2  <= 1'b1;
        wb_rw_p2   <= is_load_p1 & rw_p1;
        wb_rd_p2   <= rd_p1;
        wb_data_p2 <= is_load_p1 ? steer_load : alu_p1;
      end else if (timeout) begin
        state_p1 <= IDLE;
        req_p1   <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (launch) begin
      size_p1    <= MemSize;
      signed_p1  <= MemSigned;
      alu_p1     <= ALUResult;
      is_load_p1 <= MemRead;
      rw_p1      <= RegWrite_In;
      rd_p1      <= RegDest_In;
    end
  end

  assign MemReq      = req_p1;
  assign MemWe       = we_p1;
  assign MemAddr     = maddr_p1;
  assign MemByteEn   = be_p1;
  assign MemWData    = wdata_p1;
  assign WB_Valid    = wb_vld_p2;
  assign WB_RegWrite = wb_rw_p2;
  assign WB_RegDest  = wb_rd_p2;
  assign WB_Data     = wb_data_p2;
  assign AddrError   = addr_err_p2;

endmodule
